// File: rtl/cp0_pkg.sv
// cp0_pkg: shared register numbers, exception codes and field positions
// for the coprocessor-0 block.
package cp0_pkg;

  // CP0 register numbers (mfc0/mtc0 rd field)
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_SR       = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;

  // Exception codes; EXC_NONE marks an M-stage instruction with no fault
  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12,
    EXC_NONE    = 5'd31
  } exc_code_e;

  // SR field positions
  localparam int SR_IE     = 0;
  localparam int SR_EXL    = 1;
  localparam int SR_IM_LO  = 10;

  // Cause field positions
  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_TI     = 30;
  localparam int CAUSE_DC     = 27;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_EXC_LO = 2;

  // Address-error codes are the only ones that capture BadVAddr
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer with the sticky TI flag. Count free-runs
// unless disabled by DC; a Compare write clears TI and wins over a match.
module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        dc,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  // Count/Compare/TI state; match uses the pre-increment registered values
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      count   <= '0;
      compare <= '1;
      ti      <= 1'b0;
    end else begin
      if (count_we)
        count <= wdata;
      else if (!dc)
        count <= count + 32'd1;

      if (compare_we) begin
        compare <= wdata;
        ti      <= 1'b0;
      end else if (count == compare) begin
        ti      <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_gen2.sv
// cp0_gen2: coprocessor 0 beside the M stage. Owns SR, Cause, EPC, BadVAddr
// and PRId; raises req for interrupts/exceptions with interrupts first.
// Build option: define CP0_TIMER_EN to add Count/Compare and the TI line.
module cp0_gen2
  import cp0_pkg::*;
#(
  parameter int          NUM_HWINT  = 6,
  parameter int          TIMER_LINE = 5,
  parameter logic [31:0] PRID_VALUE = 32'h0000_0720
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [4:0]           addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  input  logic [31:0]          vpc,
  input  logic                 bd_in,
  input  logic [4:0]           exc_code,
  input  logic [31:0]          bad_vaddr_in,
  input  logic [NUM_HWINT-1:0] hw_int,
  input  logic                 eret,
  output logic [31:0]          epc_out,
  output logic                 req,
  output logic                 timer_irq
);

  logic [5:0]           sr_im_q;
  logic                 sr_exl_q, sr_ie_q;
  logic                 cause_bd_q;
  logic [NUM_HWINT-1:0] cause_ip_q;
  logic [4:0]           cause_exc_q;
  logic [31:0]          epc_q, badvaddr_q;

  logic [31:0]          count_val, compare_val;
  logic                 dc_q;

  logic [NUM_HWINT-1:0] merged_hw, pend;
  logic                 sr_write;
  logic [5:0]           eff_im;
  logic                 eff_exl, eff_ie;
  logic                 int_req, exc_req;
  logic [4:0]           final_code;
  logic [31:0]          sr_word, cause_word;

`ifdef CP0_TIMER_EN
  logic count_we, compare_we;

  // Timer writes share the mtc0 rule: dropped when an exception is taken
  assign count_we   = we && !req && (addr == CP0_COUNT);
  assign compare_we = we && !req && (addr == CP0_COMPARE);

  cp0_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .dc         (dc_q),
    .count_we   (count_we),
    .compare_we (compare_we),
    .wdata      (wdata),
    .count      (count_val),
    .compare    (compare_val),
    .ti         (timer_irq)
  );

  // Cause.DC is the only writable Cause bit
  always_ff @(posedge clk) begin
    if (reset)
      dc_q <= 1'b0;
    else if (we && !req && (addr == CP0_CAUSE))
      dc_q <= wdata[CAUSE_DC];
  end
`else
  assign count_val   = '0;
  assign compare_val = '0;
  assign dc_q        = 1'b0;
  assign timer_irq   = 1'b0;
`endif

  // Request logic, using SR fields bypassed from a same-cycle mtc0
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves a value held, which would infer a latch.
    merged_hw             = hw_int;
    merged_hw[TIMER_LINE] = hw_int[TIMER_LINE] | timer_irq;

    sr_write = we && (addr == CP0_SR);
    eff_im   = sr_write ? wdata[SR_IM_LO +: 6] : sr_im_q;
    eff_exl  = sr_write ? wdata[SR_EXL]        : sr_exl_q;
    eff_ie   = sr_write ? wdata[SR_IE]         : sr_ie_q;

    pend       = merged_hw & eff_im[NUM_HWINT-1:0];
    int_req    = (|pend) && !eff_exl && eff_ie;
    exc_req    = (exc_code != EXC_NONE) && !eff_exl;
    req        = int_req || exc_req;
    final_code = int_req ? 5'(EXC_INT) : exc_code;
  end

  // Architectural register updates: req > mtc0 > eret
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im_q     <= '0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= '0;
      cause_exc_q <= '0;
      epc_q       <= '0;
      badvaddr_q  <= '0;
    end else begin
      cause_ip_q <= merged_hw;
      if (req) begin
        epc_q       <= bd_in ? (vpc - 32'd4) : vpc;
        cause_bd_q  <= bd_in;
        cause_exc_q <= final_code;
        sr_exl_q    <= 1'b1;
        if (is_addr_exc(final_code))
          badvaddr_q <= bad_vaddr_in;
      end else begin
        // eret first so a same-cycle SR write overrides EXL
        if (eret)
          sr_exl_q <= 1'b0;
        if (we) begin
          case (addr)
            CP0_SR: begin
              sr_im_q  <= wdata[SR_IM_LO +: 6];
              sr_exl_q <= wdata[SR_EXL];
              sr_ie_q  <= wdata[SR_IE];
            end
            CP0_EPC: epc_q <= wdata;
            default: ;
          endcase
        end
      end
    end
  end

  // Read-side register images and the mfc0 mux
  always_comb begin
    sr_word                = '0;
    sr_word[SR_IM_LO +: 6] = sr_im_q;
    sr_word[SR_EXL]        = sr_exl_q;
    sr_word[SR_IE]         = sr_ie_q;

    cause_word                           = '0;
    cause_word[CAUSE_BD]                 = cause_bd_q;
    cause_word[CAUSE_TI]                 = timer_irq;
    cause_word[CAUSE_DC]                 = dc_q;
    cause_word[CAUSE_IP_LO +: NUM_HWINT] = cause_ip_q;
    cause_word[CAUSE_EXC_LO +: 5]        = cause_exc_q;

    case (addr)
      CP0_BADVADDR: rdata = badvaddr_q;
      CP0_COUNT:    rdata = count_val;
      CP0_COMPARE:  rdata = compare_val;
      CP0_SR:       rdata = sr_word;
      CP0_CAUSE:    rdata = cause_word;
      CP0_EPC:      rdata = epc_q;
      CP0_PRID:     rdata = PRID_VALUE;
      default:      rdata = '0;
    endcase

    epc_out = (we && (addr == CP0_EPC)) ? wdata : epc_q;
  end

endmodule

// File: tb/tb_cp0_gen2.sv
// tb_cp0_gen2: directed bench for cp0_gen2 with a register-image model that
// is checked against the DUT on every cycle, plus literal expectations.
// Timer sections follow CP0_TIMER_EN like the design.
module tb_cp0_gen2;
  import cp0_pkg::*;

  localparam int          NHW  = 6;
  localparam int          TL   = 5;
  localparam logic [31:0] PRID = 32'h0000_0720;

  logic           clk = 1'b0;
  logic           reset;
  logic           we;
  logic [4:0]     addr;
  logic [31:0]    wdata, rdata, vpc, bad_vaddr_in, epc_out;
  logic           bd_in, eret, req, timer_irq;
  logic [4:0]     exc_code;
  logic [NHW-1:0] hw_int;

  int n_pass  = 0;
  int n_total = 0;

  // Model: one 32-bit image per CP0 register number 0..15
  logic [31:0] mreg [0:15];
  logic [31:0] nreg [0:15];
  bit          model_valid = 1'b0;

  cp0_gen2 #(.NUM_HWINT(NHW), .TIMER_LINE(TL), .PRID_VALUE(PRID)) dut (
    .clk          (clk),
    .reset        (reset),
    .we           (we),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .vpc          (vpc),
    .bd_in        (bd_in),
    .exc_code     (exc_code),
    .bad_vaddr_in (bad_vaddr_in),
    .hw_int       (hw_int),
    .eret         (eret),
    .epc_out      (epc_out),
    .req          (req),
    .timer_irq    (timer_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---- model rules ----
  function automatic logic [31:0] m_sr();
    return (we && addr == 5'd12) ? wdata : mreg[12];
  endfunction

  function automatic logic [5:0] m_merged();
    logic [5:0] h;
    h = hw_int;
    if (mreg[13][30]) h[TL] = 1'b1;
    return h;
  endfunction

  function automatic logic m_int_req();
    logic [31:0] s;
    s = m_sr();
    return (|(m_merged() & s[15:10])) && !s[1] && s[0];
  endfunction

  function automatic logic m_req();
    logic [31:0] s;
    s = m_sr();
    return m_int_req() || ((exc_code != 5'd31) && !s[1]);
  endfunction

  function automatic logic [31:0] m_rdata();
    case (addr)
      5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15: return mreg[addr[3:0]];
      default: return 32'h0;
    endcase
  endfunction

  // Model state advance on each clock edge
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) nreg[i] = 32'h0;
      nreg[15] = PRID;
`ifdef CP0_TIMER_EN
      nreg[11] = 32'hFFFF_FFFF;
`endif
      for (int i = 0; i < 16; i++) mreg[i] <= nreg[i];
      model_valid <= 1'b1;
    end else begin : step
      logic       r;
      logic [4:0] code;
      r    = m_req();
      code = m_int_req() ? 5'd0 : exc_code;
      for (int i = 0; i < 16; i++) nreg[i] = mreg[i];
`ifdef CP0_TIMER_EN
      if (we && !r && addr == 5'd9) nreg[9] = wdata;
      else if (!mreg[13][27])        nreg[9] = mreg[9] + 32'd1;
      if (we && !r && addr == 5'd11) begin
        nreg[11]     = wdata;
        nreg[13][30] = 1'b0;
      end else if (mreg[9] == mreg[11]) begin
        nreg[13][30] = 1'b1;
      end
`endif
      nreg[13][15:10] = m_merged();
      if (r) begin
        nreg[14]       = bd_in ? vpc - 32'd4 : vpc;
        nreg[13][31]   = bd_in;
        nreg[13][6:2]  = code;
        nreg[12][1]    = 1'b1;
        if (code == 5'd4 || code == 5'd5) nreg[8] = bad_vaddr_in;
      end else begin
        if (eret) nreg[12][1] = 1'b0;
        if (we && addr == 5'd12) nreg[12] = wdata & 32'h0000_FC03;
        if (we && addr == 5'd14) nreg[14] = wdata;
`ifdef CP0_TIMER_EN
        if (we && addr == 5'd13) nreg[13][27] = wdata[27];
`endif
      end
      for (int i = 0; i < 16; i++) mreg[i] <= nreg[i];
    end
  end

  // Compare process: all outputs against the model every cycle
  always @(negedge clk) begin
    if (model_valid) begin
      check("rdata",     rdata,                  m_rdata());
      check("req",       {31'b0, req},           {31'b0, m_req()});
      check("epc_out",   epc_out,                (we && addr == 5'd14) ? wdata : mreg[14]);
      check("timer_irq", {31'b0, timer_irq},     {31'b0, mreg[13][30]});
    end
  end

  // ---- stimulus helpers ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; addr = 5'd0; wdata = 32'h0; eret = 1'b0;
    exc_code = 5'd31; hw_int = '0; bd_in = 1'b0;
    vpc = 32'h0000_0400; bad_vaddr_in = 32'hDEAD_BEEF;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle(); we = 1'b1; addr = a; wdata = d;
    tick();
    idle();
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e, input string n);
    idle(); addr = a;
    @(negedge clk);
    check(n, rdata, e);
    tick();
  endtask

  task automatic do_eret();
    idle(); eret = 1'b1;
    tick();
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("rst_req",       {31'b0, req},       32'h0);
    check("rst_epc_out",   epc_out,            32'h0);
    check("rst_timer_irq", {31'b0, timer_irq}, 32'h0);
    tick();
    reset = 1'b0;

    // Reset values of the register map
    rd(5'd9,  32'h0, "rst_count");
    rd(5'd8,  32'h0, "rst_badvaddr");
    rd(5'd10, 32'h0, "rst_unmapped10");
`ifdef CP0_TIMER_EN
    rd(5'd11, 32'hFFFF_FFFF, "rst_compare");
`else
    rd(5'd11, 32'h0, "rst_compare_off");
`endif
    rd(5'd12, 32'h0, "rst_sr");
    rd(5'd13, 32'h0, "rst_cause");
    rd(5'd14, 32'h0, "rst_epc");
    rd(5'd15, PRID,  "rst_prid");

    // Hardware interrupt on IP[10]
    mtc0(5'd12, 32'h0000_0401);
    idle(); hw_int = 6'b000001; vpc = 32'h0000_1000;
    @(negedge clk);
    check("int_req", {31'b0, req}, 32'h1);
    tick();
    rd(5'd13, 32'h0000_0400, "int_cause");
    rd(5'd12, 32'h0000_0403, "int_sr_exl");
    rd(5'd14, 32'h0000_1000, "int_epc");
    do_eret();
    rd(5'd12, 32'h0000_0401, "eret_sr");

    // AdEL in a delay slot
    idle(); exc_code = 5'd4; bd_in = 1'b1; vpc = 32'h0000_3010; bad_vaddr_in = 32'h0000_1003;
    @(negedge clk);
    check("adel_req", {31'b0, req}, 32'h1);
    tick();
    rd(5'd13, 32'h8000_0010, "adel_cause");
    rd(5'd14, 32'h0000_300C, "adel_epc");
    rd(5'd8,  32'h0000_1003, "adel_badvaddr");
    do_eret();

    // Interrupt beats a simultaneous overflow
    idle(); hw_int = 6'b000001; exc_code = 5'd12; vpc = 32'h0000_2400;
    @(negedge clk);
    check("prio_req", {31'b0, req}, 32'h1);
    tick();
    rd(5'd13, 32'h0000_0400, "prio_cause");
    rd(5'd14, 32'h0000_2400, "prio_epc");
    do_eret();

    // Same-cycle SR write bypasses into req, then is dropped
    mtc0(5'd12, 32'h0);
    idle(); we = 1'b1; addr = 5'd12; wdata = 32'h0000_0401; hw_int = 6'b000001; vpc = 32'h0000_2000;
    @(negedge clk);
    check("bypass_req", {31'b0, req}, 32'h1);
    tick();
    rd(5'd12, 32'h0000_0002, "bypass_sr");
    rd(5'd14, 32'h0000_2000, "bypass_epc");
    do_eret();

    // Exception and eret together: EXL ends up set
    idle(); exc_code = 5'd10; eret = 1'b1; vpc = 32'h0000_2800;
    @(negedge clk);
    check("reteret_req", {31'b0, req}, 32'h1);
    tick();
    rd(5'd12, 32'h0000_0002, "reteret_sr");
    rd(5'd13, 32'h0000_0028, "reteret_cause");
    do_eret();

    // EPC write bypass to epc_out
    idle(); we = 1'b1; addr = 5'd14; wdata = 32'h5555_0000;
    @(negedge clk);
    check("epc_bypass", epc_out, 32'h5555_0000);
    tick();
    rd(5'd14, 32'h5555_0000, "epc_written");

    // Read-only registers ignore writes
    mtc0(5'd15, 32'h0);
    mtc0(5'd8,  32'h0000_FFFF);
    rd(5'd15, PRID,          "prid_ro");
    rd(5'd8,  32'h0000_1003, "badvaddr_ro");

    // EXL blocks exceptions
    mtc0(5'd12, 32'h0000_0002);
    idle(); exc_code = 5'd12;
    @(negedge clk);
    check("exl_block", {31'b0, req}, 32'h0);
    tick();
    do_eret();

`ifdef CP0_TIMER_EN
    // Timer: Count=0x10, Compare=0x14, TI routed to IP[15]
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd9,  32'h0000_0010);
    mtc0(5'd11, 32'h0000_0014);
    tick(); tick(); tick();
    @(negedge clk);
    check("ti_before_match", {31'b0, timer_irq}, 32'h0);
    tick();
    addr = 5'd9;
    @(negedge clk);
    check("ti_set",        {31'b0, timer_irq}, 32'h1);
    check("ti_req",        {31'b0, req},       32'h1);
    check("ti_count",      rdata,              32'h0000_0015);
    tick();
    rd(5'd13, 32'h4000_8000, "ti_cause");
    mtc0(5'd11, 32'h0000_0100);
    @(negedge clk);
    check("ti_cleared", {31'b0, timer_irq}, 32'h0);
    tick();
    mtc0(5'd12, 32'h0);

    // Count wrap and DC hold
    mtc0(5'd9, 32'hFFFF_FFFF);
    rd(5'd9, 32'hFFFF_FFFF, "count_max");
    rd(5'd9, 32'h0,         "count_wrap");
    mtc0(5'd13, 32'h0800_0000);
    rd(5'd9,  32'h0000_0002, "dc_hold_a");
    rd(5'd9,  32'h0000_0002, "dc_hold_b");
    rd(5'd13, 32'h0800_0000, "dc_cause");
    mtc0(5'd13, 32'h0);
`else
    // Timer absent: Count/Compare/DC read 0 and ignore writes
    mtc0(5'd9,  32'h0000_0005);
    rd(5'd9,  32'h0, "off_count");
    mtc0(5'd11, 32'h0000_0005);
    rd(5'd11, 32'h0, "off_compare");
    mtc0(5'd13, 32'h0800_0000);
    addr = 5'd13;
    @(negedge clk);
    check("off_timer_irq", {31'b0, timer_irq}, 32'h0);
    check("off_dc_cause",  rdata,              32'h0000_0028);
    tick();
`endif

    // Reset during an exception cycle: no EPC capture
    idle(); exc_code = 5'd8; vpc = 32'h0000_7000;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd(5'd14, 32'h0, "rst_mid_epc");
    rd(5'd12, 32'h0, "rst_mid_sr");
    rd(5'd13, 32'h0, "rst_mid_cause");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
